// File: rtl/dm_lsu.sv
`default_nettype none
// ============================================================================
// dm_lsu : data-memory load/store unit (sized/extended loads, lane-merged stores)
// Rev 1.0
// ============================================================================
module dm_lsu #(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_op,
  output logic [31:0] rd,
  output logic        addr_err
);

  localparam logic [2:0] C_OP_W   = 3'd0;
  localparam logic [2:0] C_OP_H   = 3'd1;
  localparam logic [2:0] C_OP_HU  = 3'd2;
  localparam logic [2:0] C_OP_B   = 3'd3;
  localparam logic [2:0] C_OP_BU  = 3'd4;

  logic [31:0]   mem_q [WORDS];
  logic [31:0]   word_d;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic          w_is_word, w_is_half, w_is_byte, w_illegal;
  logic [15:0]   w_half;
  logic [7:0]    w_byte;
  logic [3:0]    w_be;
  logic [31:0]   w_lane_src;
  logic          w_we;
  logic          w_unused;

  // Upper address bits are deliberately ignored: the array aliases.
  assign w_unused = &{1'b0, addr[31:AW+2]};

  assign w_idx     = addr[AW+1:2];
  assign w_word    = mem_q[w_idx];
  assign w_is_word = (mem_op == C_OP_W);
  assign w_is_half = (mem_op == C_OP_H) || (mem_op == C_OP_HU);
  assign w_is_byte = (mem_op == C_OP_B) || (mem_op == C_OP_BU);
  assign w_illegal = ~(w_is_word | w_is_half | w_is_byte);

  assign addr_err = (mem_read | mem_write) &
                    (w_illegal | (w_is_word & (addr[1:0] != 2'b00)) | (w_is_half & addr[0]));

  assign w_half = addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_byte = w_word[7:0];
    case (addr[1:0])
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      2'd3:    w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase
  end

  always_comb begin
    rd = 32'h0;
    if (mem_read && !addr_err) begin
      case (mem_op)
        C_OP_W:  rd = w_word;
        C_OP_H:  rd = {{16{w_half[15]}}, w_half};
        C_OP_HU: rd = {16'h0, w_half};
        C_OP_B:  rd = {{24{w_byte[7]}}, w_byte};
        C_OP_BU: rd = {24'h0, w_byte};
        default: rd = 32'h0;
      endcase
    end
  end

  // Replicate the store data into every lane; the byte enables pick which land.
  always_comb begin
    w_be       = 4'b0000;
    w_lane_src = {4{wd[7:0]}};
    if (w_is_word) begin
      w_be       = 4'b1111;
      w_lane_src = wd;
    end else if (w_is_half) begin
      w_be       = addr[1] ? 4'b1100 : 4'b0011;
      w_lane_src = {2{wd[15:0]}};
    end else if (w_is_byte) begin
      w_be       = 4'b0001 << addr[1:0];
      w_lane_src = {4{wd[7:0]}};
    end
  end

  generate
    for (genvar i = 0; i < 4; i++) begin : g_lane
      assign word_d[8*i +: 8] = w_be[i] ? w_lane_src[8*i +: 8] : w_word[8*i +: 8];
    end
  endgenerate

  assign w_we = mem_write & ~addr_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (w_we) begin
      mem_q[w_idx] <= word_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_lsu.sv
`default_nettype none
// ============================================================================
// tb_dm_lsu : directed-vector scoreboard bench for dm_lsu
// Rev 1.0
// ============================================================================
module tb_dm_lsu;

  localparam logic [2:0] W = 3'd0, H = 3'd1, HU = 3'd2, B = 3'd3, BU = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  mem_op = '0;
  logic [31:0] rd;
  logic        addr_err;

  dm_lsu #(.WORDS(1024), .AW(10)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wd(wd), .mem_read(mem_read),
    .mem_write(mem_write), .mem_op(mem_op), .rd(rd), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  logic [31:0] exp_rd_q[$];
  logic        exp_err_q[$];
  string       name_q[$];
  logic        mon_valid = 1'b0;
  logic        drain = 1'b0;
  logic        mon_done = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  // Monitor: compares whenever the stimulus side flags the current cycle as checked.
  always @(negedge clk) begin
    if (mon_valid) begin
      n_checks++;
      if (exp_rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: rd=%h addr_err=%b with no expectation", rd, addr_err);
      end else begin
        automatic logic [31:0] e_rd  = exp_rd_q.pop_front();
        automatic logic        e_err = exp_err_q.pop_front();
        automatic string       nm    = name_q.pop_front();
        if (rd !== e_rd || addr_err !== e_err) begin
          n_fail++;
          $display("FAIL %s: got rd=%h addr_err=%b, expected rd=%h addr_err=%b",
                   nm, rd, addr_err, e_rd, e_err);
        end
      end
    end else if (drain && !mon_done) begin
      n_checks++;
      if (exp_rd_q.size() != 0) begin
        n_fail++;
        $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_rd_q.size());
      end
      mon_done <= 1'b1;
    end
  end

  task automatic step(input logic r, input logic rdn, input logic wr, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] d, input bit chk,
                      input logic [31:0] e_rd, input logic e_err, input string nm);
    @(posedge clk);
    #1;
    rst = r; mem_read = rdn; mem_write = wr; mem_op = op; addr = a; wd = d;
    mon_valid = chk;
    if (chk) begin
      exp_rd_q.push_back(e_rd);
      exp_err_q.push_back(e_err);
      name_q.push_back(nm);
    end
  endtask

  task automatic ld(input logic [2:0] op, input logic [31:0] a, input logic [31:0] e_rd,
                    input logic e_err, input string nm);
    step(1'b0, 1'b1, 1'b0, op, a, 32'h0, 1'b1, e_rd, e_err, nm);
  endtask

  task automatic st(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                    input logic e_err, input string nm);
    step(1'b0, 1'b0, 1'b1, op, a, d, 1'b1, 32'h0, e_err, nm);
  endtask

  initial begin
    // Reset for one edge; outputs are combinational and quiet with enables low.
    step(1'b1, 1'b0, 1'b0, W, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, "reset_outputs");
    ld(W, 32'h0,   32'h0, 1'b0, "lw_0_after_reset");
    ld(W, 32'h4,   32'h0, 1'b0, "lw_4_after_reset");
    ld(W, 32'hFFC, 32'h0, 1'b0, "lw_ffc_after_reset");

    st(W,  32'h10, 32'h8899AABB, 1'b0, "sw_10");
    ld(W,  32'h10, 32'h8899AABB, 1'b0, "lw_10");
    ld(B,  32'h10, 32'hFFFFFFBB, 1'b0, "lb_10");
    ld(B,  32'h11, 32'hFFFFFFAA, 1'b0, "lb_11");
    ld(BU, 32'h12, 32'h00000099, 1'b0, "lbu_12");
    ld(BU, 32'h13, 32'h00000088, 1'b0, "lbu_13");
    ld(H,  32'h12, 32'hFFFF8899, 1'b0, "lh_12");
    ld(HU, 32'h10, 32'h0000AABB, 1'b0, "lhu_10");
    ld(H,  32'h10, 32'hFFFFAABB, 1'b0, "lh_10");

    st(B,  32'h11, 32'h12345677, 1'b0, "sb_11");
    ld(W,  32'h10, 32'h889977BB, 1'b0, "lw_10_after_sb");
    st(H,  32'h12, 32'hFFFF0102, 1'b0, "sh_12");
    ld(W,  32'h10, 32'h010277BB, 1'b0, "lw_10_after_sh");
    st(BU, 32'h13, 32'h000000EE, 1'b0, "sbu_13");
    ld(W,  32'h10, 32'hEE0277BB, 1'b0, "lw_10_after_sbu");

    ld(W,  32'h22, 32'h0, 1'b1, "lw_misaligned_22");
    st(W,  32'h20, 32'h5A5A5A5A, 1'b0, "sw_20");
    st(H,  32'h21, 32'hFFFFFFFF, 1'b1, "sh_misaligned_21");
    st(W,  32'h22, 32'hFFFFFFFF, 1'b1, "sw_misaligned_22");
    ld(W,  32'h20, 32'h5A5A5A5A, 1'b0, "lw_20_unchanged");
    ld(H,  32'h23, 32'h0, 1'b1, "lh_misaligned_23");
    ld(BU, 32'h23, 32'h0000005A, 1'b0, "lbu_23");
    ld(3'd6, 32'h20, 32'h0, 1'b1, "illegal_op6_read");
    st(3'd5, 32'h20, 32'h0, 1'b1, "illegal_op5_write");
    ld(W,  32'h20, 32'h5A5A5A5A, 1'b0, "lw_20_after_illegal");
    step(1'b0, 1'b0, 1'b0, 3'd7, 32'h23, 32'h0, 1'b1, 32'h0, 1'b0, "illegal_op_idle");

    st(W,  32'h1000, 32'hCAFEF00D, 1'b0, "sw_1000_alias");
    ld(W,  32'h0,        32'hCAFEF00D, 1'b0, "lw_0_alias");
    ld(W,  32'hFFFF1000, 32'hCAFEF00D, 1'b0, "lw_high_alias");

    step(1'b0, 1'b1, 1'b1, W, 32'h40, 32'h11111111, 1'b1, 32'h0, 1'b0, "rdw_old_data");
    ld(W,  32'h40, 32'h11111111, 1'b0, "lw_40_new");
    step(1'b1, 1'b0, 1'b1, W, 32'h40, 32'h22222222, 1'b1, 32'h0, 1'b0, "sw_during_reset");
    ld(W,  32'h40, 32'h0, 1'b0, "lw_40_after_reset");
    ld(W,  32'h10, 32'h0, 1'b0, "lw_10_after_reset");
    ld(W,  32'h20, 32'h0, 1'b0, "lw_20_after_reset");

    @(posedge clk);
    #1;
    mon_valid = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    drain = 1'b1;
    for (int i = 0; i < 20 && !mon_done; i++) @(posedge clk);
    if (!mon_done) begin
      $display("FAIL monitor_timeout: monitor did not finish draining");
      $fatal(1, "monitor timeout");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dm_lsu.md
Name: dm_lsu

Overview:
- Data-memory load/store unit directly downstream of the ALU in the single-cycle datapath.
- Takes the ALU result as the effective byte address and the rt register value as store data.
- Performs word, halfword and byte loads (sign- or zero-extended) and stores with byte-lane merging into a word-organised memory array.
- Returns load data to the write-back mux. Flags misaligned or illegal accesses and suppresses their side effects.

Parameters:
- WORDS, 1024, memory depth in 32-bit words; must be a power of two.
- AW, 10, word-index width (log2 WORDS); byte address bits [AW+1:2] select the word.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- addr  in  32  effective byte address (ALU result c).
- wd  in  32  store data (rt value); low byte/half is used for sb/sh.
- mem_read  in  1  load enable.
- mem_write  in  1  store enable.
- mem_op  in  3  access size/extension: 0 word, 1 half signed, 2 half unsigned, 3 byte signed, 4 byte unsigned, 5-7 illegal.
- rd  out  32  load result, already extended.
- addr_err  out  1  access fault: misaligned address or illegal mem_op.

Behaviour:
- Storage: WORDS x 32-bit array, little-endian byte lanes. Byte 0 = bits [7:0] of addr[1:0]=0. Half 0 = bits [15:0].
- Word select: addr[AW+1:2]. Bits above AW+1 are ignored, so addresses alias modulo 4*WORDS. No range fault.
- Read path is combinational within the cycle: rd = f(array[word], addr[1:0], mem_op).
  - word: full 32 bits.
  - half: lane addr[1]; sign- or zero-extended to 32 bits.
  - byte: lane addr[1:0]; sign- or zero-extended to 32 bits.
- rd = 0 when mem_read=0 or addr_err=1. It never shows stale or partial data.
- addr_err (combinational) = (mem_read|mem_write) & (illegal mem_op | (word & addr[1:0]!=0) | (half & addr[0]!=0)). It is 0 when neither enable is high.
- Store on rising edge when mem_write=1, addr_err=0 and rst=0.
  - word: all 4 lanes = wd.
  - half: lanes {addr[1]*2, +1} = wd[15:0].
  - byte: lane addr[1:0] = wd[7:0].
  - All other lanes of the word are unchanged.
  - Signed/unsigned variants store identically.
- Faulted store: array is unchanged.
- Reset: when rst=1 at a rising edge, every array word becomes 0 and any concurrent store is discarded (reset has priority). The array reads as all-zero from the cycle after reset.
- Outputs under reset: rd and addr_err remain combinational. With enables low they read 0.
- Read-during-write, same address: rd shows the pre-edge contents during the cycle. The new value is visible the following cycle. No forwarding.
- mem_read and mem_write both high: both act. Read returns old data and the store commits at the edge; this is legal.
- Decode guarantees one access per instruction. The block has no internal state besides the array, no latency beyond one edge for stores, and zero cycles for loads.

Test Plan:
- rst=1 for one edge, then lw from 0x0, 0x4, 0xFFC -> rd=0x00000000, addr_err=0.
- sw wd=0x8899AABB to 0x10; next cycle lw 0x10 -> 0x8899AABB. Then lb 0x10 -> 0xFFFFFFBB; lbu 0x13 -> 0x00000088; lh 0x12 -> 0xFFFF8899; lhu 0x10 -> 0x0000AABB.
- Over 0x8899AABB at 0x10: sb wd=0x12345677 to 0x11, then sh wd=0xFFFF0102 to 0x12; lw 0x10 -> 0x010277BB.
- lw 0x22 -> addr_err=1, rd=0. sh to 0x21 with wd=0xFFFFFFFF -> addr_err=1; subsequent lw 0x20 is unchanged. mem_op=6 with mem_read=1 -> addr_err=1.
- Aliasing with WORDS=1024: sw 0xCAFEF00D to 0x1000; lw 0x0 -> 0xCAFEF00D.
- Same-cycle sw 0x11111111 to 0x40 with mem_read=1 -> rd shows old 0x0; next cycle reads 0x11111111. Then sw 0x22222222 to 0x40 with rst=1 on the same edge -> lw 0x40 = 0x0.
